mem_access_ctrl: RTL

//  Upstream bus sequencer for the 256x16 negedge-clocked single-port Memory.

---
 rtl/mem_access_ctrl_if.sv | 30 +++
 rtl/mem_access_ctrl.sv | 71 +++++++
 2 files changed

// File: rtl/mem_access_ctrl_if.sv
// mem_access_ctrl_if: request/response handshake plus Memory strobe bus for mem_access_ctrl
// Ports: Req_* request channel, Rsp_* response channel, Mem_* Memory-side address/data/strobes.
// slave = controller view; master = surrounding system (upstream requester and Memory together).
interface mem_access_ctrl_if #(
  parameter int AddrWidth = 8,
  parameter int DataWidth = 16
);
  logic                 Req_Valid;
  logic                 Req_Ready;
  logic                 Req_Write;
  logic [AddrWidth-1:0] Req_Addr;
  logic [DataWidth-1:0] Req_WData;
  logic                 Rsp_Valid;
  logic                 Rsp_Ready;
  logic                 Rsp_Write;
  logic [DataWidth-1:0] Rsp_RData;
  logic [AddrWidth-1:0] Mem_Addr;
  logic [DataWidth-1:0] Mem_DIn;
  logic                 Mem_En_N;
  logic                 Mem_WE_N;
  logic [DataWidth-1:0] Mem_DOut;
  modport slave (
    input  Req_Valid, Req_Write, Req_Addr, Req_WData, Rsp_Ready, Mem_DOut,
    output Req_Ready, Rsp_Valid, Rsp_Write, Rsp_RData, Mem_Addr, Mem_DIn, Mem_En_N, Mem_WE_N
  );
  modport master (
    output Req_Valid, Req_Write, Req_Addr, Req_WData, Rsp_Ready, Mem_DOut,
    input  Req_Ready, Rsp_Valid, Rsp_Write, Rsp_RData, Mem_Addr, Mem_DIn, Mem_En_N, Mem_WE_N
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: one-at-a-time sequencer in front of a negedge-clocked single-port Memory
// Ports: Clk (FSM on posedge), Reset (async, active low), bus (mem_access_ctrl_if.slave).
// Memory strobes are registered on posedge so address/data/strobes are stable at the Memory's negedge.
module mem_access_ctrl #(
  parameter int AddrWidth  = 8,
  parameter int DataWidth  = 16,
  parameter int WaitStates = 0
) (
  input logic              Clk,
  input logic              Reset,
  mem_access_ctrl_if.slave bus
);
  localparam logic [3:0] WS = 4'(WaitStates);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t               state_q, state_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic [DataWidth-1:0] din_q, din_d;
  logic                 en_n_q, en_n_d;
  logic                 we_n_q, we_n_d;
  logic [3:0]           cnt_q, cnt_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic                 rsp_write_q, rsp_write_d;
  logic [DataWidth-1:0] rdata_q, rdata_d;
  logic                 accept, done, release_rsp;
  assign accept      = state_q == IDLE && bus.Req_Valid;
  assign done        = state_q == ACCESS && cnt_q == 4'd0;
  assign release_rsp = state_q == RESP && bus.Rsp_Ready;
  always_ff @(posedge Clk or negedge Reset)
    if (!Reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      din_q       <= '0;
      en_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      cnt_q       <= 4'd0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      din_q       <= din_d;
      en_n_q      <= en_n_d;
      we_n_q      <= we_n_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rdata_q     <= rdata_d;
    end
  always_comb
    state_d = accept ? ACCESS : done ? RESP : release_rsp ? IDLE : state_q;
  // While in ACCESS, we_n_q still encodes the accepted operation, so no separate op flop is kept.
  always_comb begin
    addr_d      = accept ? bus.Req_Addr : addr_q;
    din_d       = accept ? (bus.Req_Write ? bus.Req_WData : '0) : din_q;
    en_n_d      = accept ? 1'b0 : done ? 1'b1 : en_n_q;
    we_n_d      = accept ? ~bus.Req_Write : done ? 1'b1 : we_n_q;
    cnt_d       = accept ? WS : (state_q == ACCESS && cnt_q != 4'd0) ? cnt_q - 4'd1 : cnt_q;
    rsp_valid_d = done ? 1'b1 : release_rsp ? 1'b0 : rsp_valid_q;
    rsp_write_d = done ? ~we_n_q : rsp_write_q;
    rdata_d     = done ? (we_n_q ? bus.Mem_DOut : '0) : rdata_q;
  end
  assign bus.Req_Ready = state_q == IDLE;
  assign bus.Rsp_Valid = rsp_valid_q;
  assign bus.Rsp_Write = rsp_write_q;
  assign bus.Rsp_RData = rdata_q;
  assign bus.Mem_Addr  = addr_q;
  assign bus.Mem_DIn   = din_q;
  assign bus.Mem_En_N  = en_n_q;
  assign bus.Mem_WE_N  = we_n_q;
endmodule
